// File: rtl/fifo_ctrl_pkg.sv
// Shared types for the FIFO pointer/flag controller.
//   state_t        : controller state, 2-bit encoding
//   is_empty_state : true for states in which the FIFO reports empty
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PARTIAL = 2'd1,
    S_FULL    = 2'd2,
    S_FLUSH   = 2'd3
  } state_t;

  // A flush drains everything, so it reports empty just like S_EMPTY.
  function automatic logic is_empty_state(input state_t s);
    return (s == S_EMPTY) || (s == S_FLUSH);
  endfunction

endpackage

// File: rtl/fifo_ptr_counter.sv
// Wrap-around pointer counter for the FIFO controller.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset, ptr -> 0
//   clear : synchronous flush, ptr -> 0 (wins over inc)
//   inc   : advance ptr by one, natural wrap at 2**WIDTH
//   ptr   : current pointer value (registered)
module fifo_ptr_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  logic [WIDTH-1:0] r_ptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (clear) begin
      r_ptr <= '0;
    end else if (inc) begin
      r_ptr <= r_ptr + WIDTH'(1);
    end
  end

  assign ptr = r_ptr;

endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for a synchronous FIFO of 2**ADDR_BITS entries.
//   clk, rst      : clock; asynchronous active-high reset
//   clear         : synchronous flush (overrides requests)
//   wr_req/rd_req : producer/consumer requests
//   wr_accept     : combinational write taken; also the array write strobe
//   rd_accept     : combinational read taken
//   wr_addr/rd_addr : registered array addresses (pointer LSBs)
//   count         : registered occupancy 0..depth
//   full/empty    : registered flags
//   overflow_err/underflow_err : one-cycle pulses for rejected requests
module fifo_ptr_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int ADDR_BITS = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic                 wr_req,
  input  logic                 rd_req,
  output logic                 wr_accept,
  output logic                 rd_accept,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [ADDR_BITS-1:0] rd_addr,
  output logic [ADDR_BITS:0]   count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int PW = ADDR_BITS + 1;
  localparam logic [PW-1:0] LP_DEPTH = {1'b1, {ADDR_BITS{1'b0}}};

  state_t        r_state;
  state_t        w_state_nxt;
  logic [PW-1:0] r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf;
  logic          r_unf;

  logic          w_wr_acc;
  logic          w_rd_acc;
  logic [PW-1:0] w_wr_ptr;
  logic [PW-1:0] w_rd_ptr;
  logic [PW-1:0] w_wr_ptr_nxt;
  logic [PW-1:0] w_rd_ptr_nxt;
  logic [PW-1:0] w_cnt_nxt;

  // Accepts come only from registered flags, so they never loop through count.
  assign w_wr_acc = wr_req & ~r_full & (r_state != S_FLUSH) & ~clear;
  assign w_rd_acc = rd_req & ~r_empty & ~clear;

  fifo_ptr_counter #(.WIDTH(PW)) u_wr_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (w_wr_acc),
    .ptr   (w_wr_ptr)
  );

  fifo_ptr_counter #(.WIDTH(PW)) u_rd_ptr (
    .clk   (clk),
    .rst   (rst),
    .clear (clear),
    .inc   (w_rd_acc),
    .ptr   (w_rd_ptr)
  );

  // Occupancy is registered from the post-edge pointer values, so it lines
  // up with wr_addr/rd_addr on the same edge.
  assign w_wr_ptr_nxt = w_wr_ptr + {{ADDR_BITS{1'b0}}, w_wr_acc};
  assign w_rd_ptr_nxt = w_rd_ptr + {{ADDR_BITS{1'b0}}, w_rd_acc};
  assign w_cnt_nxt    = clear ? '0 : (w_wr_ptr_nxt - w_rd_ptr_nxt);

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = S_FLUSH;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_wr_acc) begin
            w_state_nxt = (w_cnt_nxt == LP_DEPTH) ? S_FULL : S_PARTIAL;
          end
        end
        S_PARTIAL: begin
          if (w_wr_acc && !w_rd_acc && (w_cnt_nxt == LP_DEPTH)) begin
            w_state_nxt = S_FULL;
          end else if (w_rd_acc && !w_wr_acc && (w_cnt_nxt == '0)) begin
            w_state_nxt = S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_rd_acc) begin
            w_state_nxt = (w_cnt_nxt == '0) ? S_EMPTY : S_PARTIAL;
          end
        end
        S_FLUSH: w_state_nxt = S_EMPTY;
        default: w_state_nxt = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_cnt_nxt;
      r_full  <= (w_state_nxt == S_FULL);
      r_empty <= is_empty_state(w_state_nxt);
      r_ovf   <= wr_req & r_full & ~clear;
      // Requests during a flush are dropped silently.
      r_unf   <= rd_req & r_empty & ~clear & (r_state != S_FLUSH);
    end
  end

  assign wr_accept     = w_wr_acc;
  assign rd_accept     = w_rd_acc;
  assign wr_addr       = w_wr_ptr[ADDR_BITS-1:0];
  assign rd_addr       = w_rd_ptr[ADDR_BITS-1:0];
  assign count         = r_count;
  assign full          = r_full;
  assign empty         = r_empty;
  assign overflow_err  = r_ovf;
  assign underflow_err = r_unf;

endmodule
